// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encodings for both directions, timing widths
// and frame-length helpers.
package uart_pkg;

    localparam int unsigned PRESCALE_W = 16;
    localparam int unsigned SUB_W      = 3;
    localparam int unsigned SUB_BITS   = 8;
    localparam int unsigned BIT_CNT_W  = 4;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } tx_state_e;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Received word as handed from the receiver to its consumer
    typedef struct packed {
        logic [8:0] data;
        logic       parity_err;
        logic       frame_err;
    } uart_rx_word_t;

    function automatic int unsigned frame_bits(input int unsigned data_width,
                                               input bit          parity_en,
                                               input int unsigned stop_bits);
        return 1 + data_width + (parity_en ? 1 : 0) + stop_bits;
    endfunction

    function automatic int unsigned frame_cycles(input int unsigned data_width,
                                                 input bit          parity_en,
                                                 input int unsigned stop_bits,
                                                 input int unsigned prescale);
        return frame_bits(data_width, parity_en, stop_bits) * SUB_BITS * prescale;
    endfunction

endpackage

// File: rtl/uart_baud_gen.sv
// Bit-period timer: one-cycle bit_tick_o in the last cycle of every 8*Prescale-cycle
// bit while enabled; counters sit at zero while disabled so a new frame starts aligned.
module uart_baud_gen
    import uart_pkg::*;
#(
    parameter logic [PRESCALE_W-1:0] Prescale = 16'd27
) (
    input  logic clk_i,
    input  logic reset_ni,
    input  logic enable_i,
    output logic bit_tick_o
);

    localparam logic [PRESCALE_W-1:0] PreLast = Prescale - PRESCALE_W'(1);
    localparam logic [SUB_W-1:0]      SubLast = SUB_W'(SUB_BITS - 1);

    logic [PRESCALE_W-1:0] pre_q, pre_d;
    logic [SUB_W-1:0]      sub_q, sub_d;
    logic                  tick_q, tick_d;

    // Tick is computed one cycle ahead so it lands in the final cycle of the bit
    always_comb begin
        pre_d  = '0;
        sub_d  = '0;
        tick_d = 1'b0;
        if (enable_i) begin
            if (pre_q == PreLast) begin
                pre_d = '0;
                sub_d = sub_q + SUB_W'(1);
            end else begin
                pre_d = pre_q + PRESCALE_W'(1);
                sub_d = sub_q;
            end
            tick_d = (pre_d == PreLast) && (sub_d == SubLast);
        end
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            pre_q  <= '0;
            sub_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            sub_q  <= sub_d;
            tick_q <= tick_d;
        end
    end

    assign bit_tick_o = tick_q;

endmodule

// File: rtl/uart_tx.sv
// UART transmitter: valid/ready capture into a shift register, then start, data
// (LSB first), optional parity and stop bits on a registered, idle-high line.
module uart_tx
    import uart_pkg::*;
#(
    parameter int unsigned           DataWidth = 8,
    parameter logic [PRESCALE_W-1:0] Prescale  = 16'd27,
    parameter bit                    ParityEn  = 1'b0,
    parameter bit                    ParityOdd = 1'b0,
    parameter int unsigned           StopBits  = 1
) (
    input  logic                 clk_i,
    input  logic                 reset_ni,
    input  logic [DataWidth-1:0] data_i,
    input  logic                 valid_i,
    output logic                 ready_o,
    output logic                 tx_data_o,
    output logic                 busy_o
);

    localparam logic [BIT_CNT_W-1:0] DataLast = BIT_CNT_W'(DataWidth - 1);
    localparam logic [BIT_CNT_W-1:0] StopLast = BIT_CNT_W'(StopBits - 1);

    tx_state_e              state_q, state_d;
    logic [DataWidth-1:0]   shift_q, shift_d;
    logic                   parity_q, parity_d;
    logic [BIT_CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic                   tx_q, tx_d;
    logic                   ready_q, ready_d;
    logic                   busy_q, busy_d;
    logic                   bit_tick;
    logic                   transfer;

    assign transfer = valid_i && ready_q;

    uart_baud_gen #(
        .Prescale (Prescale)
    ) u_baud_gen (
        .clk_i      (clk_i),
        .reset_ni   (reset_ni),
        .enable_i   (busy_q),
        .bit_tick_o (bit_tick)
    );

    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        bit_cnt_d = bit_cnt_q;
        tx_d      = tx_q;

        unique case (state_q)
            IDLE: begin
                tx_d = 1'b1;
                if (transfer) begin
                    state_d   = START;
                    shift_d   = data_i;
                    parity_d  = (^data_i) ^ ParityOdd;
                    bit_cnt_d = '0;
                    tx_d      = 1'b0;
                end
            end
            START: begin
                if (bit_tick) begin
                    state_d   = DATA;
                    tx_d      = shift_q[0];
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = '0;
                end
            end
            DATA: begin
                if (bit_tick) begin
                    if (bit_cnt_q == DataLast) begin
                        bit_cnt_d = '0;
                        if (ParityEn) begin
                            state_d = PARITY;
                            tx_d    = parity_q;
                        end else begin
                            state_d = STOP;
                            tx_d    = 1'b1;
                        end
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                        tx_d      = shift_q[0];
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            PARITY: begin
                if (bit_tick) begin
                    state_d = STOP;
                    tx_d    = 1'b1;
                end
            end
            STOP: begin
                tx_d = 1'b1;
                if (bit_tick) begin
                    if (bit_cnt_q == StopLast) begin
                        state_d   = IDLE;
                        bit_cnt_d = '0;
                    end else begin
                        bit_cnt_d = bit_cnt_q + BIT_CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = IDLE;
                tx_d    = 1'b1;
            end
        endcase

        // Handshake flags track the registered state so ready rises with IDLE
        ready_d = (state_d == IDLE);
        busy_d  = ~ready_d;
    end

    always_ff @(posedge clk_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q   <= IDLE;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            bit_cnt_q <= '0;
            tx_q      <= 1'b1;
            ready_q   <= 1'b1;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            bit_cnt_q <= bit_cnt_d;
            tx_q      <= tx_d;
            ready_q   <= ready_d;
            busy_q    <= busy_d;
        end
    end

    assign ready_o   = ready_q;
    assign busy_o    = busy_q;
    assign tx_data_o = tx_q;

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: four configurations share one clock and reset; each frame is
// compared cycle by cycle against a line-level model built from the framing rules.
module tb_uart_tx;

    logic       clk;
    logic       rst_n;
    logic [7:0] din [4];
    logic [3:0] vin;
    wire  [3:0] tx;
    wire  [3:0] rdy;
    wire  [3:0] bsy;

    int total;
    int bad;

    // 0: Prescale 2, 8N1   1: Prescale 2, even parity   2: Prescale 1, 2 stop   3: Prescale 1, odd parity
    uart_tx #(.DataWidth(8), .Prescale(16'd2), .ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(1)) u_a (
        .clk_i(clk), .reset_ni(rst_n), .data_i(din[0]), .valid_i(vin[0]),
        .ready_o(rdy[0]), .tx_data_o(tx[0]), .busy_o(bsy[0]));
    uart_tx #(.DataWidth(8), .Prescale(16'd2), .ParityEn(1'b1), .ParityOdd(1'b0), .StopBits(1)) u_b (
        .clk_i(clk), .reset_ni(rst_n), .data_i(din[1]), .valid_i(vin[1]),
        .ready_o(rdy[1]), .tx_data_o(tx[1]), .busy_o(bsy[1]));
    uart_tx #(.DataWidth(8), .Prescale(16'd1), .ParityEn(1'b0), .ParityOdd(1'b0), .StopBits(2)) u_c (
        .clk_i(clk), .reset_ni(rst_n), .data_i(din[2]), .valid_i(vin[2]),
        .ready_o(rdy[2]), .tx_data_o(tx[2]), .busy_o(bsy[2]));
    uart_tx #(.DataWidth(8), .Prescale(16'd1), .ParityEn(1'b1), .ParityOdd(1'b1), .StopBits(1)) u_d (
        .clk_i(clk), .reset_ni(rst_n), .data_i(din[3]), .valid_i(vin[3]),
        .ready_o(rdy[3]), .tx_data_o(tx[3]), .busy_o(bsy[3]));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int period(input int i);
        return (i <= 1) ? 16 : 8;
    endfunction

    function automatic bit par_en(input int i);
        return (i == 1) || (i == 3);
    endfunction

    function automatic int nbits(input int i);
        return 1 + 8 + (par_en(i) ? 1 : 0) + ((i == 2) ? 2 : 1);
    endfunction

    // Expected line level during bit slot j of a frame carrying b
    function automatic logic exp_level(input int i, input logic [7:0] b, input int j);
        if (j == 0) return 1'b0;
        if (j <= 8) return b[j-1];
        if (par_en(i) && j == 9) return (^b) ^ (i == 3);
        return 1'b1;
    endfunction

    // Call just after the transfer-setup negedge; returns at the negedge ending the frame + 1 cycle
    task automatic check_frame(input int i, input logic [7:0] b, input bit toggle, input bit drop_valid);
        int         p;
        int         nb;
        int         n;
        int         busy_bad;
        logic [11:0] bit_bad;
        logic [7:0]  dec;
        p = period(i);
        nb = nbits(i);
        n = p * nb;
        busy_bad = 0;
        bit_bad = '0;
        dec = '0;
        @(negedge clk);
        for (int k = 0; k < n; k++) begin
            int j;
            j = k / p;
            if (tx[i] !== exp_level(i, b, j)) bit_bad[j] = 1'b1;
            if (j >= 1 && j <= 8 && (k % p) == p / 2) dec[j-1] = tx[i];
            if (rdy[i] !== 1'b0 || bsy[i] !== 1'b1) busy_bad++;
            if (toggle) begin
                din[i] = 8'($urandom);
                vin[i] = (k < n - 2) ? 1'($urandom) : 1'b0;
            end else if (drop_valid) begin
                vin[i] = 1'b0;
            end
            @(negedge clk);
        end
        for (int j = 0; j < nb; j++) begin
            total++;
            if (bit_bad[j]) begin
                bad++;
                $display("FAIL frame_bit inst=%0d byte=%02h slot=%0d: line not held at required %0b for %0d cycles",
                         i, b, j, exp_level(i, b, j), p);
            end
        end
        total++;
        if (dec !== b) begin
            bad++;
            $display("FAIL decode inst=%0d: got %02h required %02h", i, dec, b);
        end
        total++;
        if (busy_bad !== 0) begin
            bad++;
            $display("FAIL busy_in_frame inst=%0d: %0d cycles with ready/busy wrong, required 0", i, busy_bad);
        end
        total++;
        if (rdy[i] !== 1'b1 || bsy[i] !== 1'b0 || tx[i] !== 1'b1) begin
            bad++;
            $display("FAIL frame_end inst=%0d: ready=%b busy=%b tx=%b required 1 0 1", i, rdy[i], bsy[i], tx[i]);
        end
    endtask

    task automatic send(input int i, input logic [7:0] b, input bit toggle);
        @(negedge clk);
        din[i] = b;
        vin[i] = 1'b1;
        check_frame(i, b, toggle, 1'b1);
    endtask

    task automatic test_reset();
        int idle_bad;
        rst_n = 1'b0;
        vin = 4'hF;
        for (int i = 0; i < 4; i++) din[i] = 8'h00;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            total++;
            if (tx[i] !== 1'b1 || rdy[i] !== 1'b1 || bsy[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset_state inst=%0d: tx=%b ready=%b busy=%b required 1 1 0", i, tx[i], rdy[i], bsy[i]);
            end
        end
        rst_n = 1'b1;
        vin = 4'h0;
        idle_bad = 0;
        repeat (40) begin
            @(negedge clk);
            if (tx !== 4'hF || rdy !== 4'hF || bsy !== 4'h0) idle_bad++;
        end
        total++;
        if (idle_bad !== 0) begin
            bad++;
            $display("FAIL idle_hold: %0d idle cycles not high/ready, required 0", idle_bad);
        end
    endtask

    task automatic test_basic();
        send(0, 8'hA5, 1'b0);
        send(0, 8'h00, 1'b0);
        send(0, 8'hFF, 1'b0);
    endtask

    task automatic test_parity();
        send(1, 8'hA5, 1'b0);
        send(3, 8'hA5, 1'b0);
        send(1, 8'h01, 1'b0);
        send(3, 8'h01, 1'b0);
    endtask

    task automatic test_back_to_back();
        @(negedge clk);
        din[2] = 8'h00;
        vin[2] = 1'b1;
        check_frame(2, 8'h00, 1'b0, 1'b0);
        din[2] = 8'hFF;
        check_frame(2, 8'hFF, 1'b0, 1'b1);
    endtask

    task automatic test_toggle();
        send(0, 8'h3C, 1'b1);
        send(1, 8'hC3, 1'b1);
    endtask

    task automatic test_midframe_reset();
        @(negedge clk);
        din[0] = 8'h00;
        vin[0] = 1'b1;
        @(negedge clk);
        vin[0] = 1'b0;
        repeat (5 * 16 + 8 - 1) @(negedge clk);
        total++;
        if (tx[0] !== 1'b0) begin
            bad++;
            $display("FAIL pre_abort_bit: tx=%b required 0", tx[0]);
        end
        rst_n = 1'b0;
        #1;
        total++;
        if (tx[0] !== 1'b1 || rdy[0] !== 1'b1 || bsy[0] !== 1'b0) begin
            bad++;
            $display("FAIL async_abort: tx=%b ready=%b busy=%b required 1 1 0", tx[0], rdy[0], bsy[0]);
        end
        #2;
        rst_n = 1'b1;
        send(0, 8'h5A, 1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 256; n++) send(0, 8'($urandom), 1'b0);
        for (int n = 0; n < 12; n++) begin
            send(1, 8'($urandom), 1'($urandom));
            send(2, 8'($urandom), 1'($urandom));
            send(3, 8'($urandom), 1'($urandom));
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        test_reset();
        test_basic();
        test_parity();
        test_back_to_back();
        test_toggle();
        test_midframe_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
